// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - four-master AHB arbiter: round-robin grant, burst and lock protection
module ahb_arbiter #(
  parameter logic [3:0] HMASTER_M0     = 4'd0,
  parameter logic [3:0] HMASTER_M1     = 4'd1,
  parameter logic [3:0] HMASTER_M2     = 4'd2,
  parameter logic [3:0] HMASTER_M3     = 4'd3,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [3:0] HBUSREQx,
  input  logic [3:0] HLOCKx,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  input  logic       HREADY,
  input  logic [1:0] HRESP,
  output logic [3:0] HGRANTx,
  output logic [3:0] HMASTER,
  output logic [3:0] HMASTERD,
  output logic       HMASTLOCK
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] DEF_IDX      = 2'(DEFAULT_MASTER);

  function automatic logic [3:0] encode(input logic [1:0] idx);
    case (idx)
      2'd0:    encode = HMASTER_M0;
      2'd1:    encode = HMASTER_M1;
      2'd2:    encode = HMASTER_M2;
      default: encode = HMASTER_M3;
    endcase
  endfunction

  logic [1:0] g;
  logic [1:0] g_next;
  logic [1:0] pick;
  logic       found;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic [3:0] burst_len;
  logic       nonseq_load;
  logic       locked;
  logic       rearb;

  // SEQ beats that follow a NONSEQ of each burst type
  always_comb begin
    burst_len = 4'd0;
    case (HBURST)
      3'b010, 3'b011: burst_len = 4'd3;
      3'b100, 3'b101: burst_len = 4'd7;
      3'b110, 3'b111: burst_len = 4'd15;
      default:        burst_len = 4'd0;
    endcase
  end

  always_comb begin
    cnt_next = cnt;
    if (HREADY) begin
      case (HTRANS)
        TRANS_NONSEQ: cnt_next = burst_len;
        TRANS_SEQ:    cnt_next = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
        TRANS_IDLE:   cnt_next = 4'd0;
        TRANS_BUSY:   cnt_next = cnt;
        default:      cnt_next = cnt;
      endcase
    end else if (HRESP != RESP_OKAY) begin
      cnt_next = 4'd0;
    end
  end

  assign nonseq_load = HREADY && (HTRANS == TRANS_NONSEQ) && (burst_len != 4'd0);
  assign locked      = HLOCKx[g] && HBUSREQx[g];
  assign rearb       = (cnt == 4'd0) && !nonseq_load && !locked;

  // Round-robin scan starts after the current holder; the holder itself is the last candidate
  always_comb begin
    pick  = DEF_IDX;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && HBUSREQx[g + 2'(k)]) begin
        pick  = g + 2'(k);
        found = 1'b1;
      end
    end
    g_next = rearb ? pick : g;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      g         <= DEF_IDX;
      HGRANTx   <= 4'b0001 << DEF_IDX;
      HMASTER   <= encode(DEF_IDX);
      HMASTERD  <= encode(DEF_IDX);
      HMASTLOCK <= 1'b0;
      cnt       <= 4'd0;
    end else begin
      g       <= g_next;
      HGRANTx <= 4'b0001 << g_next;
      cnt     <= cnt_next;
      if (HREADY) begin
        HMASTERD  <= HMASTER;
        HMASTER   <= encode(g);
        HMASTLOCK <= HLOCKx[g];
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - directed self-checking bench for ahb_arbiter
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] HBUSREQx;
  logic [3:0] HLOCKx;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [1:0] HRESP;
  logic [3:0] HGRANTx;
  logic [3:0] HMASTER;
  logic [3:0] HMASTERD;
  logic       HMASTLOCK;

  int checks = 0;
  int errors = 0;

  ahb_arbiter dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HBUSREQx  (HBUSREQx),
    .HLOCKx    (HLOCKx),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HGRANTx   (HGRANTx),
    .HMASTER   (HMASTER),
    .HMASTERD  (HMASTERD),
    .HMASTLOCK (HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    HRESET   = 1'b1;
    HBUSREQx = 4'b0000;
    HLOCKx   = 4'b0000;
    HTRANS   = IDLE;
    HBURST   = 3'b000;
    HREADY   = 1'b1;
    HRESP    = 2'b00;

    // reset
    tick();
    tick();
    check("rst_grant", 32'(HGRANTx), 32'h1);
    check("rst_master", 32'(HMASTER), 32'h0);
    check("rst_masterd", 32'(HMASTERD), 32'h0);
    check("rst_lock", 32'(HMASTLOCK), 32'h0);
    HRESET = 1'b0;

    // round-robin with SINGLE transfers every cycle
    HBUSREQx = 4'b1111;
    HTRANS   = NONSEQ;
    HBURST   = 3'b000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("rr_grant", 32'(HGRANTx), 32'd1 << (k % 4));
      check("rr_master", 32'(HMASTER), 32'((k - 1) % 4));
      if (k >= 2) check("rr_masterd", 32'(HMASTERD), 32'((k - 2) % 4));
    end

    // burst protection: master 1 runs INCR8 against competing requests
    HBUSREQx = 4'b0010;
    HTRANS   = IDLE;
    tick();
    check("bp_own_grant", 32'(HGRANTx), 32'h2);
    check("bp_own_master", 32'(HMASTER), 32'h1);
    HBUSREQx = 4'b1110;
    HTRANS   = NONSEQ;
    HBURST   = 3'b101;
    tick();
    check("bp_nonseq_grant", 32'(HGRANTx), 32'h2);
    HTRANS = SEQ;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("bp_seq_grant", 32'(HGRANTx), 32'h2);
    end
    HTRANS = IDLE;
    tick();
    check("bp_release_grant", 32'(HGRANTx), 32'h4);
    check("bp_release_master", 32'(HMASTER), 32'h1);

    // wait states after grant change 0001 -> 0100
    HBUSREQx = 4'b0001;
    tick();
    tick();
    tick();
    check("ws_pre_grant", 32'(HGRANTx), 32'h1);
    check("ws_pre_masterd", 32'(HMASTERD), 32'h0);
    HBUSREQx = 4'b0100;
    tick();
    check("ws_grant", 32'(HGRANTx), 32'h4);
    check("ws_master0", 32'(HMASTER), 32'h0);
    HREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ws_hold_master", 32'(HMASTER), 32'h0);
      check("ws_hold_masterd", 32'(HMASTERD), 32'h0);
    end
    HREADY = 1'b1;
    tick();
    check("ws_master2", 32'(HMASTER), 32'h2);
    check("ws_masterd0", 32'(HMASTERD), 32'h0);
    tick();
    check("ws_masterd2", 32'(HMASTERD), 32'h2);

    // locked transfers by master 3
    HBUSREQx = 4'b1111;
    HLOCKx   = 4'b1000;
    HTRANS   = NONSEQ;
    HBURST   = 3'b001;
    tick();
    check("lk_grant_first", 32'(HGRANTx), 32'h8);
    check("lk_lock_first", 32'(HMASTLOCK), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("lk_grant_hold", 32'(HGRANTx), 32'h8);
      check("lk_master", 32'(HMASTER), 32'h3);
      check("lk_mastlock", 32'(HMASTLOCK), 32'h1);
    end
    HLOCKx = 4'b0000;
    tick();
    check("lk_release_grant", 32'(HGRANTx), 32'h1);
    check("lk_release_mastlock", 32'(HMASTLOCK), 32'h0);

    // INCR16 ended early by IDLE
    HBUSREQx = 4'b0010;
    HTRANS   = IDLE;
    tick();
    tick();
    check("et_own_master", 32'(HMASTER), 32'h1);
    HBUSREQx = 4'b1111;
    HTRANS   = NONSEQ;
    HBURST   = 3'b111;
    tick();
    HTRANS = SEQ;
    tick();
    tick();
    check("et_seq_grant", 32'(HGRANTx), 32'h2);
    HTRANS = IDLE;
    tick();
    check("et_idle_grant", 32'(HGRANTx), 32'h2);
    tick();
    check("et_rearb_grant", 32'(HGRANTx), 32'h4);

    // INCR16 ended by ERROR response
    HTRANS = NONSEQ;
    tick();
    HTRANS = SEQ;
    tick();
    check("er_seq_grant", 32'(HGRANTx), 32'h4);
    HREADY = 1'b0;
    HRESP  = 2'b01;
    tick();
    check("er_first_grant", 32'(HGRANTx), 32'h4);
    HREADY = 1'b1;
    HTRANS = IDLE;
    tick();
    check("er_rearb_grant", 32'(HGRANTx), 32'h8);
    HRESP = 2'b00;

    // reset pulse mid-INCR16
    HTRANS = NONSEQ;
    tick();
    HTRANS = SEQ;
    tick();
    check("rb_seq_grant", 32'(HGRANTx), 32'h8);
    HRESET = 1'b1;
    tick();
    check("rb_grant", 32'(HGRANTx), 32'h1);
    check("rb_master", 32'(HMASTER), 32'h0);
    check("rb_masterd", 32'(HMASTERD), 32'h0);
    check("rb_lock", 32'(HMASTLOCK), 32'h0);
    HRESET = 1'b0;
    HTRANS = IDLE;
    tick();
    check("rb_rearb_grant", 32'(HGRANTx), 32'h2);

    // no requests falls back to the default master
    HBUSREQx = 4'b0000;
    tick();
    check("def_grant", 32'(HGRANTx), 32'h1);
    check("def_master", 32'(HMASTER), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
